// File: rtl/fetch_btb_predictor_pkg.sv
// Shared definitions for the fetch-stage branch target buffer:
// counter states, the saturating counter step and PC index/tag slicing.
package fetch_btb_predictor_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // One training step of a 2-bit saturating direction counter.
  function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
    ctr_t result;
    if (taken) begin
      result = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      result = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return result;
  endfunction

  // Table index taken from the word-address bits just above the byte offset.
  function automatic logic [31:0] pc_index(logic [31:0] pc, int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag taken from the bits directly above the index field.
  function automatic logic [31:0] pc_tag(logic [31:0] pc, int unsigned idx_w,
                                         int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_btb_predictor_if.sv
// Fetch/execute-side bundle of the BTB: lookup request, training update,
// registered prediction and the hit counter.
interface fetch_btb_predictor_if;

  logic        stall;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_next_pc;
  logic [31:0] hit_count;

  modport master (
    output stall, flush, lookup_valid, lookup_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_valid, pred_hit, pred_taken, pred_next_pc, hit_count
  );

  modport slave (
    input  stall, flush, lookup_valid, lookup_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pred_valid, pred_hit, pred_taken, pred_next_pc, hit_count
  );

endinterface

// File: rtl/fetch_btb_predictor_btb_entry_array.sv
// Direct-mapped BTB storage: valid, tag, target and counter per entry.
// One combinational lookup read port, one write port that also exposes the
// current contents of the entry it addresses, and a single-cycle flush.
module btb_entry_array
  import fetch_btb_predictor_pkg::*;
#(
  parameter int   ENTRIES  = 64,
  parameter int   TAG_W    = 8,
  parameter ctr_t CTR_INIT = 2'b01,
  parameter int   IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output ctr_t             rd_ctr,
  input  logic [IDX_W-1:0] wr_idx,
  output logic             cur_valid,
  output logic [TAG_W-1:0] cur_tag,
  output logic [31:0]      cur_target,
  output ctr_t             cur_ctr,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  ctr_t             wr_ctr
);

  logic [ENTRIES-1:0] valid_mem;
  ctr_t               ctr_mem    [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];

  assign rd_valid   = valid_mem[rd_idx];
  assign rd_tag     = tag_mem[rd_idx];
  assign rd_target  = target_mem[rd_idx];
  assign rd_ctr     = ctr_mem[rd_idx];

  assign cur_valid  = valid_mem[wr_idx];
  assign cur_tag    = tag_mem[wr_idx];
  assign cur_target = target_mem[wr_idx];
  assign cur_ctr    = ctr_mem[wr_idx];

  // Valid bits and counters: reset/flush restore the initial state, flush beats a write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_mem <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= CTR_INIT;
    end else if (flush) begin
      valid_mem <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_mem[i] <= CTR_INIT;
    end else if (wr_en) begin
      valid_mem[wr_idx] <= 1'b1;
      ctr_mem[wr_idx]   <= wr_ctr;
    end
  end

  // Tags and targets carry no reset; they only matter behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/fetch_btb_predictor.sv
// Per-PC branch target buffer beside the fetch PC register. A lookup is
// answered with a registered predicted-next-PC one cycle later; resolved
// branches from execute train the table.
module fetch_btb_predictor
  import fetch_btb_predictor_pkg::*;
#(
  parameter int   ENTRIES  = 64,
  parameter int   TAG_W    = 8,
  parameter ctr_t CTR_INIT = 2'b01
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_btb_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_target;
  ctr_t             rd_ctr;
  logic             cur_valid;
  logic [TAG_W-1:0] cur_tag;
  logic [31:0]      cur_target;
  ctr_t             cur_ctr;

  logic             wr_en;
  logic [31:0]      wr_target;
  ctr_t             wr_ctr;

  logic             look_hit;
  logic             look_taken;
  logic [31:0]      look_next_pc;
  logic             upd_hit;

  logic             pred_valid_q;
  logic             pred_hit_q;
  logic             pred_taken_q;
  logic [31:0]      pred_next_pc_q;
  logic [31:0]      hit_count_q;

  assign lookup_idx = IDX_W'(pc_index(bus.lookup_pc, IDX_W));
  assign lookup_tag = TAG_W'(pc_tag(bus.lookup_pc, IDX_W, TAG_W));
  assign upd_idx    = IDX_W'(pc_index(bus.upd_pc, IDX_W));
  assign upd_tag    = TAG_W'(pc_tag(bus.upd_pc, IDX_W, TAG_W));

  btb_entry_array #(
    .ENTRIES  (ENTRIES),
    .TAG_W    (TAG_W),
    .CTR_INIT (CTR_INIT),
    .IDX_W    (IDX_W)
  ) entries (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .rd_idx     (lookup_idx),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_target  (rd_target),
    .rd_ctr     (rd_ctr),
    .wr_idx     (upd_idx),
    .cur_valid  (cur_valid),
    .cur_tag    (cur_tag),
    .cur_target (cur_target),
    .cur_ctr    (cur_ctr),
    .wr_en      (wr_en),
    .wr_tag     (upd_tag),
    .wr_target  (wr_target),
    .wr_ctr     (wr_ctr)
  );

  assign look_hit     = rd_valid && (rd_tag == lookup_tag);
  assign look_taken   = look_hit && rd_ctr[1];
  assign look_next_pc = look_taken ? rd_target : bus.lookup_pc + 32'd4;
  assign upd_hit      = cur_valid && (cur_tag == upd_tag);

  // Training decision: strengthen/weaken on a hit, allocate on a taken miss, drop under flush.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = cur_target;
    wr_ctr    = cur_ctr;
    if (bus.upd_valid && !bus.flush) begin
      if (upd_hit) begin
        wr_en  = 1'b1;
        wr_ctr = ctr_next(cur_ctr, bus.upd_taken);
        if (bus.upd_taken) wr_target = bus.upd_target;
      end else if (bus.upd_taken) begin
        wr_en     = 1'b1;
        wr_ctr    = CTR_WT;
        wr_target = bus.upd_target;
      end
    end
  end

  // Prediction register: capture accepted lookups, drop valid on an idle cycle, hold under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid_q   <= 1'b0;
      pred_hit_q     <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_next_pc_q <= '0;
    end else if (!bus.stall) begin
      if (bus.lookup_valid) begin
        pred_valid_q   <= 1'b1;
        pred_hit_q     <= look_hit;
        pred_taken_q   <= look_taken;
        pred_next_pc_q <= look_next_pc;
      end else begin
        pred_valid_q   <= 1'b0;
      end
    end
  end

  // Saturating count of accepted lookups that hit; flush leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q <= '0;
    end else if (!bus.stall && bus.lookup_valid && look_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
      hit_count_q <= hit_count_q + 32'd1;
    end
  end

  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_hit     = pred_hit_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.pred_next_pc = pred_next_pc_q;
  assign bus.hit_count    = hit_count_q;

endmodule

// File: tb/tb_fetch_btb_predictor.sv
// Self-checking bench for fetch_btb_predictor: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// table-level behavioural model.
module tb_fetch_btb_predictor;

  localparam int ENTRIES = 64;
  localparam int TAG_W   = 8;

  logic clk;
  logic reset;
  fetch_btb_predictor_if bus ();

  fetch_btb_predictor #(
    .ENTRIES  (ENTRIES),
    .TAG_W    (TAG_W),
    .CTR_INIT (2'b01)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors;
  int checks;
  bit check_en;

  bit          m_valid  [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];

  logic        exp_valid;
  logic        exp_hit;
  logic        exp_taken;
  logic [31:0] exp_next;
  logic [31:0] exp_hits;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc / 32'd4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(logic [31:0] pc);
    return (pc / (32'd4 * ENTRIES)) % (32'd1 << TAG_W);
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    exp_valid = 1'b0;
    exp_hit   = 1'b0;
    exp_taken = 1'b0;
    exp_next  = '0;
    exp_hits  = '0;
  endtask

  // One clock edge of the table: lookup reads the old state, then flush or training applies.
  task automatic model_step();
    int i;
    bit h;
    if (!bus.stall) begin
      if (bus.lookup_valid) begin
        i = m_idx(bus.lookup_pc);
        h = m_valid[i] && (m_tag[i] == m_tagof(bus.lookup_pc));
        exp_valid = 1'b1;
        exp_hit   = h;
        exp_taken = h && (m_ctr[i] >= 2);
        exp_next  = exp_taken ? m_target[i] : bus.lookup_pc + 32'd4;
        if (h && exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    if (bus.flush) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (bus.upd_valid) begin
      i = m_idx(bus.upd_pc);
      h = m_valid[i] && (m_tag[i] == m_tagof(bus.upd_pc));
      if (h) begin
        if (bus.upd_taken) begin
          m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_target[i] = bus.upd_target;
        end else begin
          m_ctr[i]    = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (bus.upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = m_tagof(bus.upd_pc);
        m_target[i] = bus.upd_target;
        m_ctr[i]    = 2;
      end
    end
  endtask

  task automatic check_output();
    check_val("cmp pred_valid",   {31'd0, bus.pred_valid}, {31'd0, exp_valid});
    check_val("cmp pred_hit",     {31'd0, bus.pred_hit},   {31'd0, exp_hit});
    check_val("cmp pred_taken",   {31'd0, bus.pred_taken}, {31'd0, exp_taken});
    check_val("cmp pred_next_pc", bus.pred_next_pc, exp_next);
    check_val("cmp hit_count",    bus.hit_count, exp_hits);
  endtask

  // Compare process: every cycle out of reset the DUT must match the model.
  always @(negedge clk) begin
    if (check_en && !reset) check_output();
  end

  task automatic apply_stimulus(input logic lv, input logic [31:0] lpc, input logic st,
                                input logic fl, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt);
    bus.lookup_valid = lv;
    bus.lookup_pc    = lpc;
    bus.stall        = st;
    bus.flush        = fl;
    bus.upd_valid    = uv;
    bus.upd_pc       = upc;
    bus.upd_taken    = ut;
    bus.upd_target   = utgt;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    apply_stimulus(1'b1, pc, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, pc, taken, tgt);
    step();
  endtask

  task automatic check_pred(input string name, input logic v, input logic h, input logic t,
                            input logic [31:0] npc);
    check_val({name, " valid"}, {31'd0, bus.pred_valid}, {31'd0, v});
    check_val({name, " hit"},   {31'd0, bus.pred_hit},   {31'd0, h});
    check_val({name, " taken"}, {31'd0, bus.pred_taken}, {31'd0, t});
    check_val({name, " next"},  bus.pred_next_pc, npc);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] upc;
    errors   = 0;
    checks   = 0;
    check_en = 1'b0;
    reset    = 1'b1;
    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_pred("reset", 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("reset hit_count", bus.hit_count, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    check_en = 1'b1;

    do_lookup(32'h8000);
    check_pred("cold miss", 1'b1, 1'b0, 1'b0, 32'h8004);

    do_update(32'h8010, 1'b1, 32'h8100);
    check_val("idle drops valid", {31'd0, bus.pred_valid}, 32'd0);
    do_lookup(32'h8010);
    check_pred("alloc hit", 1'b1, 1'b1, 1'b1, 32'h8100);
    check_val("first hit_count", bus.hit_count, 32'd1);

    do_update(32'h8010, 1'b1, 32'h8100);
    do_update(32'h8010, 1'b0, 32'h0);
    do_lookup(32'h8010);
    check_pred("ctr 10", 1'b1, 1'b1, 1'b1, 32'h8100);
    do_update(32'h8010, 1'b0, 32'h0);
    do_lookup(32'h8010);
    check_pred("ctr 01", 1'b1, 1'b1, 1'b0, 32'h8014);
    do_update(32'h8010, 1'b0, 32'h0);
    do_update(32'h8010, 1'b0, 32'h0);
    do_lookup(32'h8010);
    check_pred("ctr 00", 1'b1, 1'b1, 1'b0, 32'h8014);
    do_update(32'h8010, 1'b1, 32'h8100);
    do_lookup(32'h8010);
    check_pred("ctr sat 00 then up", 1'b1, 1'b1, 1'b0, 32'h8014);

    do_update(32'h8110, 1'b1, 32'h9000);
    do_lookup(32'h8010);
    check_pred("evicted", 1'b1, 1'b0, 1'b0, 32'h8014);
    do_lookup(32'h8110);
    check_pred("alias owner", 1'b1, 1'b1, 1'b1, 32'h9000);

    do_update(32'h8010, 1'b1, 32'h8100);
    do_update(32'h8010, 1'b1, 32'h8100);
    apply_stimulus(1'b1, 32'h8010, 1'b0, 1'b1, 1'b1, 32'h8010, 1'b0, '0);
    step();
    check_pred("flush same cycle", 1'b1, 1'b1, 1'b1, 32'h8100);
    do_lookup(32'h8010);
    check_pred("after flush", 1'b1, 1'b0, 1'b0, 32'h8014);

    do_lookup(32'h8000);
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b1, 32'h8200 + 32'(c * 4), 1'b1, 1'b0, (c == 1), 32'h8200, 1'b1, 32'hA000);
      step();
      check_pred("stall hold", 1'b1, 1'b0, 1'b0, 32'h8004);
    end
    do_lookup(32'h8200);
    check_pred("update in stall", 1'b1, 1'b1, 1'b1, 32'hA000);

    apply_stimulus(1'b1, 32'h8004, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_pred("reset mid-stall", 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("reset mid-stall hit_count", bus.hit_count, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    do_lookup(32'h8200);
    check_pred("miss after reset", 1'b1, 1'b0, 1'b0, 32'h8204);
    do_lookup(32'hFFFF_FFFC);
    check_pred("pc wrap", 1'b1, 1'b0, 1'b0, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rpc = 32'h8000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 19) == 0) rpc = $urandom;
      upc = 32'h8000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 7)) << 2);
      apply_stimulus($urandom_range(0, 9) < 8, rpc, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, upc,
                     $urandom_range(0, 9) < 6, $urandom & 32'hFFFF_FFFC);
      step();
    end

    apply_stimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step();
    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
